rv32v_load_deserializer: RTL and testbench

Return-path counterpart of the vector memory serializer: collects the one-lane-at-a-time load responses from the load/store controller (LSC) and reassembles them into a lane-parallel result for one vector load micro-op. Sits between the LSC load-data path and the vector writeback stage. Inactive lanes are skipped, each element is truncated to the effective element width, and the assembled group is held under a valid/ready handshake.

---
 rtl/rv32v_load_deserializer.sv | 136 +++++++++++++
 tb/tb_rv32v_load_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_load_deserializer.sv
// Vector load return path: gathers per-lane LSC load responses in ascending
// active-lane order and presents them as one lane-parallel writeback group.
module rv32v_load_deserializer #(
  parameter int NUM_LANES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [NUM_LANES-1:0]        vlane_mask,
  input  logic [1:0]                  veew,
  input  logic [4:0]                  vuop_num,
  input  logic                        flush,
  input  logic                        resp_valid,
  input  logic [$clog2(NUM_LANES)-1:0] resp_lane,
  input  logic [31:0]                 resp_data,
  input  logic                        wb_ready,
  output logic                        ready,
  output logic                        wb_valid,
  output logic [NUM_LANES*32-1:0]     wb_data,
  output logic [NUM_LANES-1:0]        wb_lane_wen,
  output logic [4:0]                  wb_uop_num,
  output logic                        resp_err
);

  localparam int LW     = $clog2(NUM_LANES);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, COLLECT, WB} state_t;

  state_t                    state_q, state_d;
  logic [NUM_LANES-1:0]      mask_q;
  logic [1:0]                eew_q;
  logic [4:0]                uop_q;
  logic [LW-1:0]             exp_lane_q;
  logic [NUM_LANES*DATA_W-1:0] data_q;
  logic                      err_q, err_d;
  logic                      start_acc, accept;
  logic [LW:0]               first_lane, next_lane;

  // {found, index} of the lowest active lane strictly above 'after'
  function automatic logic [LW:0] next_active(input logic [NUM_LANES-1:0] mask,
                                              input int after);
    logic [LW:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask[i] && i > after) r = {1'b1, LW'(i)};
    end
    return r;
  endfunction

  // Encodings 00/01/10 select 8/16/32 bits; the reserved 11 falls to 32
  function automatic logic [DATA_W-1:0] trunc_eew(input logic [1:0] eew,
                                                 input logic [DATA_W-1:0] d);
    case (eew)
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign first_lane = next_active(vlane_mask, -1);
  assign next_lane  = next_active(mask_q, int'(exp_lane_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    start_acc = 1'b0;
    accept    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          err_d = resp_valid;
          if (start) begin
            start_acc = 1'b1;
            state_d   = first_lane[LW] ? COLLECT : WB;
          end
        end
        COLLECT: begin
          if (resp_valid) begin
            if (resp_lane == exp_lane_q) begin
              accept = 1'b1;
              if (!next_lane[LW]) state_d = WB;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WB: begin
          err_d = resp_valid;
          if (wb_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q     <= '0;
      eew_q      <= '0;
      uop_q      <= '0;
      exp_lane_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (start_acc) begin
        mask_q     <= vlane_mask;
        eew_q      <= veew;
        uop_q      <= vuop_num;
        exp_lane_q <= first_lane[LW-1:0];
        data_q     <= '0;
      end else if (accept) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (exp_lane_q == LW'(i)) data_q[i*DATA_W +: DATA_W] <= trunc_eew(eew_q, resp_data);
        end
        exp_lane_q <= next_lane[LW-1:0];
      end
    end
  end

  assign ready       = (state_q == IDLE);
  assign wb_valid    = (state_q == WB);
  assign wb_data     = data_q;
  assign wb_lane_wen = mask_q;
  assign wb_uop_num  = uop_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_rv32v_load_deserializer.sv
// Bench for rv32v_load_deserializer: directed vector table, hand-written
// corner sequences and a randomized transaction-level reference model.
module tb_rv32v_load_deserializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  vlane_mask = '0;
  logic [1:0]  veew = '0;
  logic [4:0]  vuop_num = '0;
  logic        flush = 1'b0;
  logic        resp_valid = 1'b0;
  logic [0:0]  resp_lane = '0;
  logic [31:0] resp_data = '0;
  logic        wb_ready = 1'b0;
  logic        ready, wb_valid, resp_err;
  logic [63:0] wb_data;
  logic [1:0]  wb_lane_wen;
  logic [4:0]  wb_uop_num;

  int checks = 0;
  int failures = 0;

  rv32v_load_deserializer #(.NUM_LANES(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .vlane_mask(vlane_mask), .veew(veew),
    .vuop_num(vuop_num), .flush(flush), .resp_valid(resp_valid),
    .resp_lane(resp_lane), .resp_data(resp_data), .wb_ready(wb_ready),
    .ready(ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_lane_wen(wb_lane_wen), .wb_uop_num(wb_uop_num), .resp_err(resp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  eew;
    logic [4:0]  uop;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [63:0] exp_data;
    logic [1:0]  exp_wen;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs are set at a negedge; tick passes one rising edge and returns at the next negedge
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] e, input logic [4:0] u);
    start = 1'b1; vlane_mask = m; veew = e; vuop_num = u;
    tick();
    start = 1'b0;
  endtask

  task automatic send_resp(input logic l, input logic [31:0] d);
    resp_valid = 1'b1; resp_lane = l; resp_data = d;
    tick();
    resp_valid = 1'b0;
  endtask

  // Element value the writeback should carry: low EEW bits of d, zero-extended
  function automatic logic [31:0] model_elem(input logic [1:0] eew, input logic [31:0] d);
    int w;
    w = (eew == 2'd0) ? 8 : (eew == 2'd1) ? 16 : 32;
    return 32'({32'b0, d} % (64'd1 << w));
  endfunction

  initial begin
    vecs[0] = '{2'b11, 2'd2, 5'd5,  32'hDEADBEEF, 32'h12345678, 64'h12345678_DEADBEEF, 2'b11};
    vecs[1] = '{2'b10, 2'd0, 5'd1,  32'h0,        32'hFFFFFFA5, 64'h000000A5_00000000, 2'b10};
    vecs[2] = '{2'b01, 2'd1, 5'd2,  32'hABCD1234, 32'h0,        64'h00000000_00001234, 2'b01};
    vecs[3] = '{2'b11, 2'd1, 5'd31, 32'h55667788, 32'h99AABBCC, 64'h0000BBCC_00007788, 2'b11};
    vecs[4] = '{2'b00, 2'd2, 5'd7,  32'h0,        32'h0,        64'h0,                 2'b00};
    vecs[5] = '{2'b11, 2'd3, 5'd9,  32'hCAFEF00D, 32'h80000001, 64'h80000001_CAFEF00D, 2'b11};

    // Reset values
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wen", wb_lane_wen, 0);
    chk("rst_uop", wb_uop_num, 0);
    chk("rst_err", resp_err, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      logic [31:0] d[2];
      d[0] = vecs[v].d0; d[1] = vecs[v].d1;
      chk("vec_ready_before", ready, 1);
      do_start(vecs[v].mask, vecs[v].eew, vecs[v].uop);
      if (vecs[v].mask != 2'b00) begin
        chk("vec_ready_busy", ready, 0);
        chk("vec_no_early_valid", wb_valid, 0);
      end
      for (int l = 0; l < 2; l++) begin
        if (vecs[v].mask[l]) begin
          send_resp(l[0], d[l]);
          chk("vec_no_err", resp_err, 0);
        end
      end
      chk("vec_wb_valid", wb_valid, 1);
      chk("vec_wb_data", wb_data, vecs[v].exp_data);
      chk("vec_wen", wb_lane_wen, vecs[v].exp_wen);
      chk("vec_uop", wb_uop_num, vecs[v].uop);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("vec_wb_done", wb_valid, 0);
      chk("vec_ready_after", ready, 1);
    end

    // Writeback stall: outputs hold until wb_ready
    do_start(2'b11, 2'd2, 5'd5);
    send_resp(1'b0, 32'hDEADBEEF);
    send_resp(1'b1, 32'h12345678);
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", wb_valid, 1);
      chk("stall_data", wb_data, 64'h12345678_DEADBEEF);
      chk("stall_wen", wb_lane_wen, 2'b11);
      chk("stall_uop", wb_uop_num, 5'd5);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("stall_release", ready, 1);

    // Wrong-lane response in COLLECT
    do_start(2'b01, 2'd1, 5'd3);
    send_resp(1'b1, 32'h1111);
    chk("wrong_lane_err", resp_err, 1);
    chk("wrong_lane_collect", ready, 0);
    chk("wrong_lane_novalid", wb_valid, 0);
    tick();
    chk("err_one_cycle", resp_err, 0);
    send_resp(1'b0, 32'hABCD1234);
    chk("after_err_valid", wb_valid, 1);
    chk("after_err_data", wb_data, 64'h00000000_00001234);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // All-masked start, then a response during WB
    do_start(2'b00, 2'd0, 5'd4);
    chk("empty_valid", wb_valid, 1);
    chk("empty_wen", wb_lane_wen, 0);
    send_resp(1'b0, 32'hFFFFFFFF);
    chk("wb_resp_err", resp_err, 1);
    chk("wb_resp_data", wb_data, 0);
    chk("wb_resp_valid", wb_valid, 1);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Flush alongside the last response
    do_start(2'b11, 2'd2, 5'd6);
    send_resp(1'b0, 32'h77);
    flush = 1'b1; resp_valid = 1'b1; resp_lane = 1'b1; resp_data = 32'h88;
    tick();
    flush = 1'b0; resp_valid = 1'b0;
    chk("flush_ready", ready, 1);
    chk("flush_valid", wb_valid, 0);
    tick();
    chk("flush_stays_idle", wb_valid, 0);
    do_start(2'b01, 2'd2, 5'd8);
    chk("restart_cleared", wb_data, 0);
    send_resp(1'b0, 32'h5);
    chk("restart_data", wb_data, 64'h00000000_00000005);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Asynchronous reset in the middle of COLLECT
    do_start(2'b11, 2'd2, 5'd10);
    send_resp(1'b0, 32'h1234);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_ready", ready, 1);
    chk("async_rst_valid", wb_valid, 0);
    chk("async_rst_data", wb_data, 0);
    @(negedge CLK);
    RST = 1'b0;
    send_resp(1'b1, 32'h9999);
    chk("post_rst_err", resp_err, 1);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_valid", wb_valid, 0);
    tick();

    // Randomized transactions against the reference model
    for (int t = 0; t < 300; t++) begin
      logic [1:0]  m, e;
      logic [4:0]  u;
      logic [31:0] d[2];
      logic [63:0] exp_data;
      m = 2'($urandom_range(0, 3));
      e = 2'($urandom_range(0, 3));
      u = 5'($urandom_range(0, 31));
      d[0] = $urandom; d[1] = $urandom;
      exp_data = {(m[1] ? model_elem(e, d[1]) : 32'h0), (m[0] ? model_elem(e, d[0]) : 32'h0)};
      chk("rnd_ready", ready, 1);
      do_start(m, e, u);
      if (m != 2'b00 && $urandom_range(0, 9) == 0) begin
        flush = 1'b1; tick(); flush = 1'b0;
        chk("rnd_flush_ready", ready, 1);
        chk("rnd_flush_valid", wb_valid, 0);
        continue;
      end
      for (int l = 0; l < 2; l++) begin
        if (m[l]) begin
          if ($urandom_range(0, 3) == 0) tick();
          if ($urandom_range(0, 3) == 0) begin
            send_resp(~l[0], $urandom);
            chk("rnd_wrong_err", resp_err, 1);
            chk("rnd_wrong_valid", wb_valid, 0);
          end
          start = ($urandom_range(0, 4) == 0);
          send_resp(l[0], d[l]);
          start = 1'b0;
          chk("rnd_ok_err", resp_err, 0);
        end
      end
      chk("rnd_valid", wb_valid, 1);
      chk("rnd_data", wb_data, exp_data);
      chk("rnd_wen", wb_lane_wen, m);
      chk("rnd_uop", wb_uop_num, u);
      for (int s = $urandom_range(0, 2); s > 0; s--) begin
        if ($urandom_range(0, 1) == 0) begin
          send_resp(1'($urandom_range(0, 1)), $urandom);
          chk("rnd_wb_err", resp_err, 1);
        end else begin
          tick();
        end
        chk("rnd_hold_data", wb_data, exp_data);
      end
      wb_ready = 1'b1; tick(); wb_ready = 1'b0;
      chk("rnd_done", wb_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
